mic_capture: RTL

Audio capture front end for the Pmod MIC3 (ADCS7476 12-bit SPI ADC). Sound generation drives 1-bit audio out to the Pmod AMP2; this block brings audio in. It clocks 16-bit frames out of the ADC at a fixed sample rate and presents each 12-bit sample with a one-cycle strobe. It also produces a 4-bit peak level suitable for a Basys3 LED meter. It runs on the 25 MHz system clock produced by the prescaler.

---
 rtl/mic_capture.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mic_capture.sv
`timescale 1ns/1ps
// mic_capture
// Audio capture front end for the Pmod MIC3, which carries an ADCS7476 12-bit
// SPI ADC. A free-running sample timer starts one conversion per period. Each
// conversion clocks a 16-bit frame out of the ADC, MSB first. The low 12 bits
// of the frame are presented as an unsigned sample with a one-cycle strobe.
// Every completed sample also feeds a peak meter. The meter reports the 4 MSBs
// of the largest distance from mid-scale seen over each window of samples.
//
// Ports
//   clk_i           system clock (25 MHz)
//   reset_i         synchronous, active-high reset
//   enable_i        allows new conversions to start
//   miso_i          ADC serial data
//   cs_n_o          ADC chip select, active low
//   sclk_o          ADC serial clock, idles high
//   sample_o        last completed unsigned sample, mid-scale 12'h800
//   sample_valid_o  one-cycle strobe when sample_o updates
//   level_o         peak magnitude of the last completed window
module mic_capture #(
    parameter int SCLK_DIV      = 4,
    parameter int SAMPLE_PERIOD = 1250,
    parameter int LEVEL_WINDOW  = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        miso_i,
    output logic        cs_n_o,
    output logic        sclk_o,
    output logic [11:0] sample_o,
    output logic        sample_valid_o,
    output logic [3:0]  level_o
);

    localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int WIN_W   = (LEVEL_WINDOW > 1) ? $clog2(LEVEL_WINDOW) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LEVEL_WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } CaptureState;

    CaptureState        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timerTick;
    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic [3:0]         bitCnt_q, bitCnt_d;
    logic               csN_q, csN_d;
    logic               sclk_q, sclk_d;
    logic [11:0]        shift_q, shift_d;
    logic               captureBit;
    logic [11:0]        sample_q, sample_d;
    logic               sampleValid_q, sampleValid_d;

    logic [10:0]        peak_q, peak_d;
    logic [WIN_W-1:0]   winCnt_q, winCnt_d;
    logic [3:0]         level_q, level_d;
    logic [11:0]        belowMid;
    logic [10:0]        magnitude;
    logic [10:0]        peakMax;

    // The sample timer free-runs whether or not capture is enabled.
    // Conversions therefore always start on the same sample grid.
    always_comb begin
        timerTick = (timer_q == TIMER_LAST);
        timer_d   = timerTick ? '0 : timer_q + 1'b1;
    end

    // A bit is taken in the first cycle that the registered sclk is high.
    // This is half an SCLK period after the ADC drove it on the falling edge.
    // Only 12 bits are kept. After 16 shifts, the 4 leading zero bits of the
    // frame have fallen off the top, so the register holds the sample.
    always_comb begin
        captureBit = (state_q == SHIFT) && sclk_q && (divCnt_q == '0);
        shift_d    = captureBit ? {shift_q[10:0], miso_i} : shift_q;
    end

    // Conversion sequencer. cs_n and sclk are computed as next-state values
    // and registered, so the pins change cleanly with the state they belong to.
    // In SHIFT, divCnt times each half period and sclk_q tells which half is
    // in progress. The frame ends after the high half of bit 15.
    always_comb begin
        state_d       = state_q;
        divCnt_d      = divCnt_q;
        bitCnt_d      = bitCnt_q;
        csN_d         = csN_q;
        sclk_d        = sclk_q;
        sample_d      = sample_q;
        sampleValid_d = 1'b0;
        case (state_q)
            IDLE: begin
                csN_d  = 1'b1;
                sclk_d = 1'b1;
                if (timerTick && enable_i) begin
                    state_d  = SETUP;
                    divCnt_d = '0;
                    csN_d    = 1'b0;
                end
            end
            SETUP: begin
                if (divCnt_q == DIV_LAST) begin
                    state_d  = SHIFT;
                    divCnt_d = '0;
                    bitCnt_d = '0;
                    sclk_d   = 1'b0;
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (divCnt_q == DIV_LAST) begin
                    divCnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bitCnt_q == 4'd15) begin
                        state_d       = DONE;
                        csN_d         = 1'b1;
                        sclk_d        = 1'b1;
                        sample_d      = shift_d;
                        sampleValid_d = 1'b1;
                    end else begin
                        sclk_d   = 1'b0;
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                csN_d   = 1'b1;
                sclk_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                csN_d   = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    // Distance of the newest sample from mid-scale. Only 12'h000 gives 2048,
    // and it is clamped to 2047 so the result fits in 11 bits. The window
    // closes on its last valid sample. That sample takes part in the final
    // peak through peakMax before the peak is cleared.
    always_comb begin
        belowMid  = 12'h800 - sample_q;
        magnitude = sample_q[11] ? sample_q[10:0]
                                 : (belowMid[11] ? 11'h7FF : belowMid[10:0]);
        peakMax   = (magnitude > peak_q) ? magnitude : peak_q;
        peak_d    = peak_q;
        winCnt_d  = winCnt_q;
        level_d   = level_q;
        if (sampleValid_q) begin
            if (winCnt_q == WIN_LAST) begin
                level_d  = peakMax[10:7];
                peak_d   = '0;
                winCnt_d = '0;
            end else begin
                peak_d   = peakMax;
                winCnt_d = winCnt_q + 1'b1;
            end
        end
    end

    // State and output registers. Reset aborts any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            divCnt_q      <= '0;
            bitCnt_q      <= '0;
            csN_q         <= 1'b1;
            sclk_q        <= 1'b1;
            shift_q       <= '0;
            sample_q      <= '0;
            sampleValid_q <= 1'b0;
            peak_q        <= '0;
            winCnt_q      <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            divCnt_q      <= divCnt_d;
            bitCnt_q      <= bitCnt_d;
            csN_q         <= csN_d;
            sclk_q        <= sclk_d;
            shift_q       <= shift_d;
            sample_q      <= sample_d;
            sampleValid_q <= sampleValid_d;
            peak_q        <= peak_d;
            winCnt_q      <= winCnt_d;
            level_q       <= level_d;
        end
    end

    assign cs_n_o         = csN_q;
    assign sclk_o         = sclk_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sampleValid_q;
    assign level_o        = level_q;

endmodule
